// File: rtl/neuron_pkg.sv
// Shared types and saturating/wrapping adder for the neuron array core.
// Build option NEURON_SAT_EN selects clamping instead of two's-complement wrap.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } neuron_state_e;

    localparam int WSEL_W     = 2;
    localparam int NUM_WTYPES = 4;

    // Operands arrive sign-extended from w bits, so the 32-bit sum is the exact (w+1)-bit sum.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] sum;
`ifdef NEURON_SAT_EN
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
`else
        sum = a + b;
        return (sum <<< (32 - w)) >>> (32 - w);
`endif
    endfunction

endpackage

// File: rtl/neuron_update.sv
// Combinational leak, threshold and reset unit shared by all neurons in the sweep.
// Leak is only used for the threshold decision; an unfired neuron keeps its old potential.
module neuron_update
    import neuron_pkg::*;
#(
    parameter int POT_W = 8
) (
    input  logic signed [POT_W-1:0] pot_i,
    input  logic signed [POT_W-1:0] leak_i,
    input  logic signed [POT_W-1:0] pos_thr_i,
    input  logic signed [POT_W-1:0] neg_thr_i,
    input  logic signed [POT_W-1:0] pos_reset_i,
    input  logic signed [POT_W-1:0] neg_reset_i,
    output logic signed [POT_W-1:0] pot_o,
    output logic                    spike_o
);

    logic signed [POT_W-1:0] leaked;

    always_comb begin
        leaked  = POT_W'(sat_add(32'(pot_i), 32'(leak_i), POT_W));
        pot_o   = pot_i;
        spike_o = 1'b0;
        if (leaked >= pos_thr_i) begin
            pot_o   = pos_reset_i;
            spike_o = 1'b1;
        end else if (leaked < neg_thr_i) begin
            pot_o = neg_reset_i;
        end
    end

endmodule

// File: rtl/neuron_array_core.sv
// Time-multiplexed integrate-and-fire neuron array: event accumulation, swept update, spike stream.
// Arithmetic saturates when NEURON_SAT_EN is defined, otherwise wraps.
module neuron_array_core
    import neuron_pkg::*;
#(
    parameter  int NUM_NEURONS = 16,
    parameter  int POT_W       = 8,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ev_valid_i,
    output logic                          ev_ready_o,
    input  logic [IDX_W-1:0]              ev_idx_i,
    input  logic [WSEL_W-1:0]             ev_wsel_i,
    input  logic [NUM_WTYPES*POT_W-1:0]   weight_i,
    input  logic signed [POT_W-1:0]       leak_i,
    input  logic signed [POT_W-1:0]       pos_thr_i,
    input  logic signed [POT_W-1:0]       neg_thr_i,
    input  logic signed [POT_W-1:0]       pos_reset_i,
    input  logic signed [POT_W-1:0]       neg_reset_i,
    input  logic                          picture_done_i,
    input  logic                          clear_i,
    output logic                          spike_valid_o,
    input  logic                          spike_ready_i,
    output logic [IDX_W-1:0]              spike_idx_o,
    output logic                          busy_o,
    output logic                          done_o
);

    neuron_state_e           state_q, state_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic                    spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
    logic signed [POT_W-1:0] pot_q [NUM_NEURONS];
    logic signed [POT_W-1:0] pot_d [NUM_NEURONS];

    logic signed [POT_W-1:0] ev_weight;
    logic                    ev_in_range;
    logic                    slot_free;
    logic signed [POT_W-1:0] upd_pot;
    logic                    upd_spike;

    assign ev_weight   = weight_i[ev_wsel_i*POT_W +: POT_W];
    assign ev_in_range = 32'(ev_idx_i) < NUM_NEURONS;
    assign slot_free   = !spike_valid_q || spike_ready_i;

    neuron_update #(
        .POT_W (POT_W)
    ) u_update (
        .pot_i       (pot_q[k_q]),
        .leak_i      (leak_i),
        .pos_thr_i   (pos_thr_i),
        .neg_thr_i   (neg_thr_i),
        .pos_reset_i (pos_reset_i),
        .neg_reset_i (neg_reset_i),
        .pot_o       (upd_pot),
        .spike_o     (upd_spike)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        spike_valid_d = spike_valid_q;
        spike_idx_d   = spike_idx_q;
        pot_d         = pot_q;

        if (spike_valid_q && spike_ready_i) begin
            spike_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Clear beats a coincident event; the sweep still starts on zeroed potentials.
                if (clear_i) begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        pot_d[i] = '0;
                    end
                end else if (ev_valid_i && ev_in_range) begin
                    pot_d[ev_idx_i] = POT_W'(sat_add(32'(pot_q[ev_idx_i]), 32'(ev_weight), POT_W));
                end
                if (picture_done_i) begin
                    state_d = SWEEP;
                    k_d     = '0;
                end
            end
            SWEEP: begin
                if (slot_free) begin
                    pot_d[k_q] = upd_pot;
                    if (upd_spike) begin
                        spike_valid_d = 1'b1;
                        spike_idx_d   = k_q;
                    end
                    if (k_q == IDX_W'(NUM_NEURONS - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            k_q           <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            pot_q         <= pot_d;
        end
    end

    // done_o must coincide with the DRAIN exit cycle, which depends on this cycle's spike_ready_i.
    assign done_o        = (state_q == DRAIN) && slot_free;
    assign busy_o        = (state_q != IDLE);
    assign ev_ready_o    = (state_q == IDLE);
    assign spike_valid_o = spike_valid_q;
    assign spike_idx_o   = spike_idx_q;

endmodule

// File: tb/tb_neuron_array_core.sv
// Directed bench for neuron_array_core with a spike-index scoreboard; honours NEURON_SAT_EN.
module tb_neuron_array_core;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          ev_valid_i;
    logic          ev_ready_o;
    logic [IW-1:0] ev_idx_i;
    logic [1:0]    ev_wsel_i;
    logic [4*PW-1:0] weight_i;
    logic signed [PW-1:0] leak_i, pos_thr_i, neg_thr_i, pos_reset_i, neg_reset_i;
    logic          picture_done_i;
    logic          clear_i;
    logic          spike_valid_o;
    logic          spike_ready_i;
    logic [IW-1:0] spike_idx_o;
    logic          busy_o;
    logic          done_o;

    neuron_array_core #(
        .NUM_NEURONS (N),
        .POT_W       (PW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ev_valid_i     (ev_valid_i),
        .ev_ready_o     (ev_ready_o),
        .ev_idx_i       (ev_idx_i),
        .ev_wsel_i      (ev_wsel_i),
        .weight_i       (weight_i),
        .leak_i         (leak_i),
        .pos_thr_i      (pos_thr_i),
        .neg_thr_i      (neg_thr_i),
        .pos_reset_i    (pos_reset_i),
        .neg_reset_i    (neg_reset_i),
        .picture_done_i (picture_done_i),
        .clear_i        (clear_i),
        .spike_valid_o  (spike_valid_o),
        .spike_ready_i  (spike_ready_i),
        .spike_idx_o    (spike_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int exp_idx;
    int sb[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Spike handshakes and done pulses are observed mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni && spike_valid_o && spike_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_spike", 32'(spike_idx_o), -1);
            end else begin
                exp_idx = sb.pop_front();
                check("spike_idx", 32'(spike_idx_o), exp_idx);
            end
        end
        if (done_o) begin
            done_cnt++;
            check("done_after_all_spikes", sb.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int idx, input int wsel);
        ev_valid_i = 1'b1;
        ev_idx_i   = IW'(idx);
        ev_wsel_i  = 2'(wsel);
        tick();
        ev_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        weight_i = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endtask

    task automatic start_sweep();
        picture_done_i = 1'b1;
        tick();
        picture_done_i = 1'b0;
    endtask

    // Returns the cycle (1 = first cycle after picture_done) on which done_o was seen, or -1.
    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic check_pots(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < N; i++) begin
            check(tag, dut.pot_q[i], e[i]);
        end
    endtask

    initial begin
        int cyc;
        int d0;
        rst_ni         = 1'b0;
        ev_valid_i     = 1'b0;
        ev_idx_i       = '0;
        ev_wsel_i      = '0;
        weight_i       = '0;
        leak_i         = 8'sd0;
        pos_thr_i      = 8'sd40;
        neg_thr_i      = -8'sd80;
        pos_reset_i    = 8'sd0;
        neg_reset_i    = -8'sd20;
        picture_done_i = 1'b0;
        clear_i        = 1'b0;
        spike_ready_i  = 1'b1;

        #12;
        check("rst_spike_valid", 32'(spike_valid_o), 0);
        check("rst_spike_idx", 32'(spike_idx_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_ev_ready", 32'(ev_ready_o), 1);
        check_pots("rst_pots", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Back-to-back accumulation on one neuron across three weight types.
        set_w(10, 20, 30, 0);
        ev_valid_i = 1'b1;
        ev_idx_i   = 2'd3;
        ev_wsel_i  = 2'd0;
        tick();
        ev_wsel_i  = 2'd1;
        tick();
        ev_wsel_i  = 2'd2;
        tick();
        ev_valid_i = 1'b0;
        check("accum_pot3", dut.pot_q[3], 60);

        // Overflow on event accumulation.
        do_clear();
        check("clear_pot3", dut.pot_q[3], 0);
        set_w(120, 20, 0, 0);
        send(0, 0);
        check("pot0_preload", dut.pot_q[0], 120);
        send(0, 1);
`ifdef NEURON_SAT_EN
        check("sat_pot0", dut.pot_q[0], 127);
`else
        check("wrap_pot0", dut.pot_q[0], -116);
`endif

        // Single sweep: {50,0,-90,10}, leak -5.
        do_clear();
        set_w(50, -90, 10, 0);
        send(0, 0);
        send(2, 1);
        send(3, 2);
        leak_i = -8'sd5;
        sb.push_back(0);
        start_sweep();
        check("sweep_busy", 32'(busy_o), 1);
        check("sweep_ev_ready", 32'(ev_ready_o), 0);
        wait_done(20, cyc);
        check("sweep_done_cycle", cyc, N + 1);
        tick();
        check("sweep_idle_busy", 32'(busy_o), 0);
        check("sweep_spikes_left", sb.size(), 0);
        check_pots("sweep_pots", 0, 0, -20, 10);

        // Every neuron fires while the output is back-pressured.
        do_clear();
        set_w(50, 0, 0, 0);
        for (int i = 0; i < N; i++) send(i, 0);
        for (int i = 0; i < N; i++) sb.push_back(i);
        spike_ready_i = 1'b0;
        d0 = done_cnt;
        start_sweep();
        for (int i = 0; i < 5; i++) @(negedge clk_i);
        check("bp_hold_valid", 32'(spike_valid_o), 1);
        check("bp_hold_idx", 32'(spike_idx_o), 0);
        check("bp_busy", 32'(busy_o), 1);
        check("bp_no_early_done", done_cnt, d0);
        tick();
        spike_ready_i = 1'b1;
        wait_done(40, cyc);
        check("bp_done_seen", 32'(cyc > 0), 1);
        tick();
        check("bp_spikes_left", sb.size(), 0);
        check_pots("bp_pots", 0, 0, 0, 0);

        // Event coincident with picture_done is visible to the sweep.
        leak_i = 8'sd0;
        do_clear();
        set_w(50, 0, 0, 0);
        sb.push_back(1);
        ev_valid_i     = 1'b1;
        ev_idx_i       = 2'd1;
        ev_wsel_i      = 2'd0;
        picture_done_i = 1'b1;
        tick();
        ev_valid_i     = 1'b0;
        picture_done_i = 1'b0;
        wait_done(20, cyc);
        check("coincide_done_cycle", cyc, N + 1);
        tick();
        check("coincide_spikes_left", sb.size(), 0);
        check("coincide_pot1", dut.pot_q[1], 0);

        // Clear wins over the coincident event; no spikes expected.
        send(3, 0);
        clear_i        = 1'b1;
        ev_valid_i     = 1'b1;
        ev_idx_i       = 2'd1;
        picture_done_i = 1'b1;
        tick();
        clear_i        = 1'b0;
        ev_valid_i     = 1'b0;
        picture_done_i = 1'b0;
        check("clear_sweep_busy", 32'(busy_o), 1);
        wait_done(20, cyc);
        check("clear_done_cycle", cyc, N + 1);
        tick();
        check_pots("clear_pots", 0, 0, 0, 0);

        // Reset while a spike is pending in the middle of a sweep.
        send(0, 0);
        send(2, 0);
        spike_ready_i = 1'b0;
        d0 = done_cnt;
        start_sweep();
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_pending_valid", 32'(spike_valid_o), 1);
        check("mid_pending_idx", 32'(spike_idx_o), 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(spike_valid_o), 0);
        check("mid_rst_idx", 32'(spike_idx_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        check("mid_rst_ev_ready", 32'(ev_ready_o), 1);
        check_pots("mid_rst_pots", 0, 0, 0, 0);
        spike_ready_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        tick();
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_idle", 32'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/neuron_array_core.md
# neuron_array_core

Time-multiplexed array of `NUM_NEURONS` integrate-and-fire neurons sharing one arithmetic datapath. Membrane potentials live in an internal register file. During a picture, weighted axon events arrive over a valid/ready stream. On `picture_done_i` the block sweeps all neurons once, applying leak, threshold and reset, and emits spikes as a back-pressured index stream. It sits between the crossbar/axon scheduler and the spike router in the 256x256 neuron core, replacing per-neuron combinational blocks.

## Interface
- `NUM_NEURONS`, 16: neurons held; index width `IDX_W = $clog2(NUM_NEURONS)`.
- `POT_W`, 8: signed width of potential, weights, thresholds, leak and resets.
- `clk_i` in 1: core clock.
- `rst_ni` in 1: reset. Asynchronous assert, active-low.
- `ev_valid_i` in 1: axon event valid.
- `ev_ready_o` out 1: event accepted when `ev_valid_i && ev_ready_o`.
- `ev_idx_i` in `IDX_W`: target neuron.
- `ev_wsel_i` in 2: weight type select, 0..3.
- `weight_i` in 4x`POT_W` (packed, type0 at LSB): signed weights.
- `leak_i`, `pos_thr_i`, `neg_thr_i`, `pos_reset_i`, `neg_reset_i` in `POT_W` each: shared signed neuron config. Must be stable while busy.
- `picture_done_i` in 1: pulse that starts the sweep.
- `clear_i` in 1: zero all potentials.
- `spike_valid_o` out 1: spike index valid.
- `spike_ready_i` in 1: downstream accepts spike.
- `spike_idx_o` out `IDX_W`: index of the spiking neuron.
- `busy_o` out 1: sweep in progress.
- `done_o` out 1: one-cycle pulse when the sweep completes and the last spike has been accepted.

## Operation
- **States:**
  - `IDLE`: accepts events and clear.
  - `SWEEP`: processes one neuron per cycle.
  - `DRAIN`: waits for the final spike to be accepted.
- **IDLE:**
  - `ev_ready_o=1`.
  - An accepted event writes `pot[idx] <= sat(pot[idx] + weight[wsel])` at the next edge.
  - `ev_idx_i >= NUM_NEURONS`: the event is accepted and dropped.
  - Back-to-back events to the same neuron accumulate correctly, with no hazards.
- **Start:** `picture_done_i` in IDLE moves to SWEEP with k=0.
  - An event accepted in the same cycle is still applied and is visible to the sweep.
- **Clear:** `clear_i` in IDLE zeroes all potentials at the next edge.
  - If it coincides with an accepted event or `picture_done_i`, clear wins: the event is dropped and the sweep still starts, on zeroed potentials.
  - `clear_i` outside IDLE is ignored.
- **SWEEP, neuron k:** compute `p = sat(pot[k] + leak_i)`. Comparisons are signed and full width.
  - `p >= pos_thr_i`: `pot[k] <= pos_reset_i` and a spike is issued with index k.
  - Else if `p < neg_thr_i`: `pot[k] <= neg_reset_i`.
  - Otherwise: `pot[k] <= pot[k]`. Leak is not retained when no threshold is crossed; this is intentional for bit-compatibility with the existing neuron model.
- **Back-pressure:** neuron k advances only if the output slot is free (`!spike_valid_o || spike_ready_i`). Otherwise the block stalls on k with no state change.
- **Sweep end:** after k = NUM_NEURONS-1 the block goes to DRAIN.
  - DRAIN exits to IDLE once `spike_valid_o` is 0, or `spike_ready_i` is 1 in that cycle.
  - `done_o` pulses on that exit cycle.
- `ev_ready_o=0` and `picture_done_i` is ignored outside IDLE.
- **Arithmetic:** sums are computed at `POT_W+1` bits, then passed through `sat()` (see Configuration).

## Timing
- **Reset values:**
  - All potentials 0 and state IDLE.
  - `spike_valid_o=0`, `spike_idx_o=0`, `busy_o=0`, `done_o=0`, `ev_ready_o=1`.
- **Reset mid-sweep:** aborts immediately. Any pending spike is lost and no `done_o` is issued.
- **Latencies:**
  - Event update is visible 1 cycle after acceptance.
  - A spike for neuron k is registered, so `spike_valid_o` rises the cycle after k is processed.
  - `spike_valid_o` and `spike_idx_o` hold until accepted.
- **Minimum sweep** with `spike_ready_i=1` throughout: `picture_done_i` at cycle 0, SWEEP occupies cycles 1..N, DRAIN is cycle N+1 with `done_o=1`, IDLE from N+2.
- **`busy_o`:** high in SWEEP and DRAIN.

## Configuration
- **`NEURON_SAT_EN` defined:** `sat()` clamps to [-2^(POT_W-1), 2^(POT_W-1)-1], for both event accumulation and leak.
- **Undefined:** `sat()` truncates to the low `POT_W` bits (two's-complement wrap). This matches legacy neuron behaviour.

## Structure
- **Package `neuron_pkg`:**
  - State enum `neuron_state_e` (IDLE/SWEEP/DRAIN).
  - `WSEL_W=2` and `NUM_WTYPES=4`.
  - The `sat_add` function, guarded by `NEURON_SAT_EN`.
- **Sub-module `neuron_update`:** combinational leak/threshold/reset unit, instantiated once. Inputs: pot, config. Outputs: next pot, spike.
- The register file and FSM stay in the top module.

## Test plan
- **Integration, POT_W=8:**
  - Stimulus: events to neuron 3 with weights {10,20,30} and `ev_wsel_i`=0,1,2 back-to-back.
  - Required: `pot[3]=60` one cycle after the last accept.
- **Saturation:**
  - Stimulus: `pot[0]=120`, event weight +20.
  - Required with `NEURON_SAT_EN`: 127. Without it: -116.
- **Sweep:**
  - Stimulus: NUM_NEURONS=4, pots {50,0,-90,10}, leak=-5, pos_thr=40, neg_thr=-80, resets 0/-20, `spike_ready_i=1`.
  - Required: single spike idx 0; final pots {0,0,-20,10}; `done_o` exactly at cycle N+1 after `picture_done_i`.
- **Back-pressure:**
  - Stimulus: all 4 neurons spike, `spike_ready_i` low for 5 cycles.
  - Required: indices 0,1,2,3 delivered in order with none lost; `done_o` only after idx 3 is accepted.
- **Simultaneous events:**
  - Stimulus 1: event (idx 1, +50) in the same cycle as `picture_done_i`, pos_thr=40.
  - Required: idx 1 spikes.
  - Stimulus 2: `clear_i` together with that event.
  - Required: no spike.
- **Reset mid-sweep:**
  - Stimulus: assert `rst_ni` low during SWEEP with a spike pending.
  - Required: all outputs at reset values asynchronously; no `done_o`; all potentials 0.
